// File: rtl/series_acc_fsm.sv
// Running accumulator of sum(k) or sum(k^2) for k = 0..targ, run under a level enable.
// Squared terms are only available when SERIES_ACC_SQUARE_EN is defined; otherwise mode is ignored.
module series_acc_fsm #(
  parameter int TARG_W = 4,
  parameter int SUM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [TARG_W-1:0] targ,
  input  logic              mode,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int PW = 2 * TARG_W;
  // One spare bit above the wider of sum/term so the carry out of SUM_W is visible
  localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [TARG_W-1:0] count;
  logic [TARG_W-1:0] targ_q;
  logic [PW-1:0]     term;
  logic [AW-1:0]     acc;
  logic              carry;

`ifdef SERIES_ACC_SQUARE_EN
  logic mode_q;
  assign term = mode_q ? (PW'(count) * PW'(count)) : PW'(count);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign term        = PW'(count);
`endif

  assign acc   = AW'(sum) + AW'(term);
  assign carry = |acc[AW-1:SUM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      sum    <= '0;
      ovf    <= 1'b0;
      targ_q <= '0;
`ifdef SERIES_ACC_SQUARE_EN
      mode_q <= 1'b0;
`endif
    end else if (!enable) begin
      state <= IDLE;
      count <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          targ_q <= targ;
`ifdef SERIES_ACC_SQUARE_EN
          mode_q <= mode;
`endif
          count  <= '0;
          sum    <= '0;
          ovf    <= 1'b0;
          state  <= COUNT;
        end
        COUNT: begin
          sum   <= acc[SUM_W-1:0];
          if (carry) ovf <= 1'b1;
          count <= count + 1'b1;
          if (count == targ_q) state <= DONE;
        end
        DONE: ; // hold results until enable drops
        default: begin
          state <= IDLE;
          count <= '0;
          sum   <= '0;
          ovf   <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == COUNT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_series_acc_fsm.sv
// Randomized self-checking bench for series_acc_fsm against closed-form series sums.
// Honours SERIES_ACC_SQUARE_EN the same way the design does.
module tb_series_acc_fsm;
  localparam int TARG_W = 4;
  localparam int SUM_W  = 8;
`ifdef SERIES_ACC_SQUARE_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [TARG_W-1:0] targ;
  logic              mode;
  logic [SUM_W-1:0]  sum;
  logic              busy, done, ovf;

  int checks = 0;
  int passes = 0;

  series_acc_fsm #(.TARG_W(TARG_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .targ(targ), .mode(mode),
    .sum(sum), .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Unbounded total of term(k) for k = 0..n (n = -1 means no terms yet)
  function automatic longint total(input int n, input bit sq);
    longint ln = n;
    if (sq) return ln * (ln + 1) * (2 * ln + 1) / 6;
    return ln * (ln + 1) / 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sum"}, 32'(sum), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  // Full run; scram randomizes targ/mode every cycle after the start edge
  task automatic run(input int t, input bit m, input bit scram, input int chg_targ);
    bit     sq = m & SQ_EN;
    longint tot;
    @(negedge clk);
    targ = TARG_W'(t); mode = m; enable = 1'b1;
    for (int j = 0; j <= t + 1; j++) begin
      @(negedge clk);  // after edge E0+j
      tot = total(j - 1, sq);
      if (j <= t) begin
        chk("run_busy", 32'(busy), 1);
        chk("run_done_early", 32'(done), 0);
      end else begin
        chk("run_done", 32'(done), 1);
        chk("run_busy_end", 32'(busy), 0);
      end
      chk("run_sum", 32'(sum), 32'(tot % (64'd1 << SUM_W)));
      chk("run_ovf", 32'(ovf), 32'(tot >= (64'd1 << SUM_W)));
      if (scram) begin targ = TARG_W'($urandom); mode = 1'($urandom); end
      if (j == 1 && chg_targ >= 0) targ = TARG_W'(chg_targ);
    end
    tot = total(t, sq);
    repeat (2) begin
      @(negedge clk);
      chk("hold_done", 32'(done), 1);
      chk("hold_sum", 32'(sum), 32'(tot % (64'd1 << SUM_W)));
      chk("hold_ovf", 32'(ovf), 32'(tot >= (64'd1 << SUM_W)));
    end
    enable = 1'b0;
    @(negedge clk);
    chk_idle("stop");
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; targ = '0; mode = 1'b0;
    #2;
    chk_idle("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset_idle");

    run(4, 1'b0, 1'b0, -1);   // sum 10
    run(15, 1'b0, 1'b0, -1);  // sum 120
    run(15, 1'b1, 1'b0, -1);  // 216/ovf with squares, else 120
    run(0, 1'b0, 1'b0, -1);   // single COUNT cycle
    run(4, 1'b0, 1'b0, 9);    // targ change mid-run ignored

    // Abort: enable sampled low at E0+3
    @(negedge clk);
    targ = 4'd10; mode = 1'b0; enable = 1'b1;
    @(negedge clk);  // after E0
    @(negedge clk);  // after E0+1
    @(negedge clk);  // after E0+2
    chk("abort_busy_before", 32'(busy), 1);
    enable = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    run(10, 1'b0, 1'b0, -1);  // restart from k=0

    // Async reset pulse while in DONE
    @(negedge clk);
    targ = 4'd15; mode = 1'b1; enable = 1'b1;
    repeat (18) @(negedge clk);
    chk("pre_rst_done", 32'(done), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    enable = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("after_rst_idle");

    for (int i = 0; i < 8; i++)
      run(int'($urandom_range(0, 15)), 1'($urandom), 1'b1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
